debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 74 +++++++
 rtl/debounce_multi.sv | 56 +++++
 tb/tb_debounce_multi.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
// Declarations only; no latency, no flow control.
package debounce_pkg;

    localparam int SAMPLE_DIV_10US = 1000;
    localparam int STABLE_5MS      = 500;

    function automatic int CLOG2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    // Counter width that still holds value-1, never narrower than one bit.
    function automatic int CNT_W(input int value);
        return (CLOG2(value) < 1) ? 1 : CLOG2(value);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability counter, registered level and edge pulses.
// Latency SYNC_STAGES + (STABLE_TICKS-1)*tick period + 1 minimum; free-running, no backpressure.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = STABLE_5MS,
    parameter int   SYNC_STAGES  = 2,
    parameter logic INIT_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = CNT_W(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   level_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // cnt == 0 is the STABLE state; any non-zero count is PENDING.
    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (tick) begin
            if (s == level) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
                cnt_nxt   = '0;
                level_nxt = s;
                rise_nxt  = s;
                fall_nxt  = ~s;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= INIT_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample prescaler feeding CHANNELS independent debounce_channel slices.
// Latency SYNC_STAGES+(STABLE_TICKS-1)*SAMPLE_DIV+1 .. SYNC_STAGES+STABLE_TICKS*SAMPLE_DIV; no backpressure.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS     = 5,
    parameter int                  SAMPLE_DIV   = SAMPLE_DIV_10US,
    parameter int                  STABLE_TICKS = STABLE_5MS,
    parameter int                  SYNC_STAGES  = 2,
    parameter logic [CHANNELS-1:0] INIT_LEVEL   = {CHANNELS{1'b0}}
) (
    input  logic                clk_100,
    input  logic                ck_rst,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int            PW        = CNT_W(SAMPLE_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;

    assign pcnt_nxt = (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;

    // tick is registered so it tracks pcnt == SAMPLE_DIV-1 yet stays low in reset.
    always_ff @(posedge clk_100 or negedge ck_rst) begin
        if (!ck_rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            pcnt <= pcnt_nxt;
            tick <= (pcnt_nxt == PCNT_LAST);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .SYNC_STAGES  (SYNC_STAGES),
            .INIT_LEVEL   (INIT_LEVEL[i])
        ) u_ch (
            .clk   (clk_100),
            .rst_n (ck_rst),
            .tick  (tick),
            .din   (din[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: window-rule reference model feeding an event scoreboard,
// directed scenarios, randomized chatter, and a degenerate-parameter instance.
module tb_debounce_multi;

    localparam int         CH   = 2;
    localparam int         DIV  = 4;
    localparam int         ST   = 3;
    localparam int         SYNC = 2;
    localparam logic [1:0] INIT = 2'b00;
    localparam int         LAT_MIN = SYNC + (ST - 1) * DIV + 1;
    localparam int         LAT_MAX = SYNC + ST * DIV;

    typedef struct {
        int cyc;
        int ch;
        bit is_rise;
    } ev_t;

    logic          clk_100 = 1'b0;
    logic          ck_rst  = 1'b0;
    logic          rst1_n  = 1'b0;
    logic [CH-1:0] din     = '0;
    logic [CH-1:0] din1    = '0;
    logic [CH-1:0] level, rise, fall;
    logic [CH-1:0] level1, rise1, fall1;
    logic          tick, tick1;

    int vectors     = 0;
    int miscompares = 0;

    int          cyc = 0;
    bit [CH-1:0] hist[$];
    bit [CH-1:0] mlevel = INIT;
    bit          win[CH][ST];
    ev_t         exp_q[$];
    int          rise_seen[CH];
    int          fall_seen[CH];
    int          last_rise[CH];

    debounce_multi #(
        .CHANNELS(CH), .SAMPLE_DIV(DIV), .STABLE_TICKS(ST),
        .SYNC_STAGES(SYNC), .INIT_LEVEL(INIT)
    ) dut (
        .clk_100(clk_100), .ck_rst(ck_rst), .din(din),
        .level(level), .rise(rise), .fall(fall), .tick(tick)
    );

    debounce_multi #(
        .CHANNELS(CH), .SAMPLE_DIV(1), .STABLE_TICKS(1),
        .SYNC_STAGES(SYNC), .INIT_LEVEL(INIT)
    ) dut1 (
        .clk_100(clk_100), .ck_rst(rst1_n), .din(din1),
        .level(level1), .rise(rise1), .fall(fall1), .tick(tick1)
    );

    initial forever #5 clk_100 = ~clk_100;

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_100);
            #1;
        end
    endtask

    // Number of most recent samples that disagree with the model level.
    function automatic int pending_cnt(input int ch);
        int  n;
        bit  run;
        n   = 0;
        run = 1'b1;
        for (int k = ST - 1; k >= 0; k--) begin
            if (run && win[ch][k] != mlevel[ch]) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

    // Reference: a level is accepted once the last ST tick samples all disagree with it.
    initial begin
        bit [CH-1:0] s;
        bit          all_diff;
        ev_t         ev;
        forever begin
            @(posedge clk_100 or negedge ck_rst);
            if (!ck_rst) begin
                cyc    = 0;
                mlevel = INIT;
                hist.delete();
                exp_q.delete();
                for (int c = 0; c < CH; c++)
                    for (int k = 0; k < ST; k++) win[c][k] = INIT[c];
            end else begin
                cyc++;
                hist.push_back(din);
                if (cyc % DIV == 0) begin
                    s = (cyc - SYNC >= 1) ? hist[cyc - SYNC - 1] : INIT;
                    for (int c = 0; c < CH; c++) begin
                        for (int k = 0; k < ST - 1; k++) win[c][k] = win[c][k + 1];
                        win[c][ST - 1] = s[c];
                        all_diff = 1'b1;
                        for (int k = 0; k < ST; k++)
                            if (win[c][k] == mlevel[c]) all_diff = 1'b0;
                        if (all_diff) begin
                            mlevel[c]  = s[c];
                            ev.cyc     = cyc;
                            ev.ch      = c;
                            ev.is_rise = s[c];
                            exp_q.push_back(ev);
                        end
                    end
                end
            end
        end
    end

    // Monitor: compares outputs each cycle and pops expected edge events.
    initial begin
        ev_t e;
        int  mtick;
        forever begin
            @(negedge clk_100);
            if (!ck_rst) begin
                chk("reset_level", int'(level), int'(INIT));
                chk("reset_pulses", int'({rise, fall}), 0);
                chk("reset_tick", int'(tick), 0);
            end else begin
                mtick = (cyc > 0 && cyc % DIV == DIV - 1) ? 1 : 0;
                chk("level", int'(level), int'(mlevel));
                chk("tick", int'(tick), mtick);
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    chk("missed_pulse_cycle", cyc, e.cyc);
                end
                for (int c = 0; c < CH; c++) begin
                    if (rise[c] && fall[c]) chk("rise_and_fall", 1, 0);
                    if (rise[c] || fall[c]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_pulse_ch", c, -1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("pulse_cycle", cyc, e.cyc);
                            chk("pulse_channel", c, e.ch);
                            chk("pulse_is_rise", int'(rise[c]), int'(e.is_rise));
                        end
                        if (rise[c]) begin
                            rise_seen[c]++;
                            last_rise[c] = cyc;
                        end
                        if (fall[c]) fall_seen[c]++;
                    end
                end
            end
        end
    end

    initial begin
        int c0, r0, r1, f0, lat, ok;
        int rs[CH];
        int fs[CH];
        int pflip;

        // Reset state
        step(3);
        chk("tick1_in_reset", int'(tick1), 0);
        chk("level1_in_reset", int'(level1), int'(INIT));
        ck_rst = 1'b1;
        rst1_n = 1'b1;

        // Clean step and return
        step(9);
        c0 = cyc;
        r0 = rise_seen[0];
        din[0] = 1'b1;
        step(LAT_MAX + 6);
        chk("clean_rise_count", rise_seen[0] - r0, 1);
        lat = last_rise[0] - c0;
        vectors++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            miscompares++;
            $display("FAIL clean_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        f0 = fall_seen[0];
        din[0] = 1'b0;
        step(LAT_MAX + 6);
        chk("clean_fall_count", fall_seen[0] - f0, 1);

        // Glitch of 9 clocks aligned to cover only two sample ticks
        ok = 0;
        for (int k = 0; k < 2 * DIV && ok == 0; k++) begin
            if (cyc % DIV == DIV - 1) ok = 1;
            else step(1);
        end
        chk("glitch_align", ok, 1);
        r0 = rise_seen[0];
        din[0] = 1'b1;
        step(9);
        din[0] = 1'b0;
        step(20);
        chk("glitch_rise_count", rise_seen[0] - r0, 0);
        chk("glitch_level", int'(level[0]), 0);

        // Chatter then settle on channel 1
        r1 = rise_seen[1];
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) din[1] = ~din[1];
            step(1);
        end
        chk("chatter_rise_count", rise_seen[1] - r1, 0);
        din[1] = 1'b1;
        step(LAT_MAX + 6);
        chk("settle_rise_count", rise_seen[1] - r1, 1);
        chk("settle_level", int'(level[1]), 1);

        // Simultaneous step on both channels
        din = 2'b00;
        step(LAT_MAX + 6);
        c0 = cyc;
        din = 2'b11;
        step(LAT_MAX + 6);
        chk("simul_same_cycle", last_rise[0], last_rise[1]);
        chk("simul_after_step", int'(last_rise[0] > c0), 1);

        // Asynchronous reset while channel 0 has two pending samples
        din[0] = 1'b0;
        ok = 0;
        for (int k = 0; k < 40 && ok == 0; k++) begin
            step(1);
            if (pending_cnt(0) == 2) ok = 1;
        end
        chk("reset_setup_pending", ok, 1);
        #2;
        ck_rst = 1'b0;
        #1;
        chk("async_level", int'(level), int'(INIT));
        chk("async_pulses", int'({rise, fall}), 0);
        chk("async_tick", int'(tick), 0);
        din = '0;
        step(3);
        for (int c = 0; c < CH; c++) begin
            rs[c] = rise_seen[c];
            fs[c] = fall_seen[c];
        end
        ck_rst = 1'b1;
        step(30);
        for (int c = 0; c < CH; c++) begin
            chk("post_reset_rise", rise_seen[c] - rs[c], 0);
            chk("post_reset_fall", fall_seen[c] - fs[c], 0);
        end

        // Randomized bursts of chatter and quiet periods
        for (int blk = 0; blk < 15; blk++) begin
            pflip = $urandom_range(2, 40);
            for (int k = 0; k < 150; k++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, pflip - 1) == 0) din[c] = ~din[c];
                step(1);
            end
        end
        step(LAT_MAX + 6);

        // Degenerate instance: SAMPLE_DIV=1, STABLE_TICKS=1
        for (int k = 0; k < 6; k++) begin
            chk("deg_tick_const", int'(tick1), 1);
            step(1);
        end
        din1[0] = 1'b1;
        for (int k = 1; k <= SYNC + 1; k++) begin
            step(1);
            chk("deg_rise_level", int'(level1[0]), (k == SYNC + 1) ? 1 : 0);
            chk("deg_rise_pulse", int'(rise1[0]), (k == SYNC + 1) ? 1 : 0);
        end
        step(2);
        din1[0] = 1'b0;
        for (int k = 1; k <= SYNC + 1; k++) begin
            step(1);
            chk("deg_fall_level", int'(level1[0]), (k == SYNC + 1) ? 0 : 1);
            chk("deg_fall_pulse", int'(fall1[0]), (k == SYNC + 1) ? 1 : 0);
        end
        chk("deg_other_channel", int'(level1[1]), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
